// File: rtl/cordic_ci_master.sv
// -----------------------------------------------------------------------------
// cordic_ci_master
//   Initiator for the multicycle custom-instruction handshake
//   (clk_en/start/done) used by the cosine/CORDIC slave units. Operands arrive
//   on an upstream valid/ready stream. Each operand is issued to the slave, and
//   the block waits for done or a timeout. The captured result (or a qNaN on
//   timeout) is then offered on a downstream valid/ready stream. Only one
//   operation is ever in flight.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   upstream operand valid
//   in_ready   operand accepted this cycle (IDLE, or HOLD while out_ready)
//   in_data    float32 operand (theta)
//   out_valid  result valid (HOLD state)
//   out_ready  downstream accepts result
//   out_data   captured result, or 32'h7FC00000 on timeout
//   out_err    1 = out_data is a timeout result
//   err_count  saturating count of timeouts since reset
//   ci_clk_en  slave clock enable (ISSUE and WAIT)
//   ci_start   one-cycle start pulse (ISSUE)
//   ci_dataa   operand to slave, driven from the operand register only
//   ci_done    slave completion pulse
//   ci_result  slave result, valid while ci_done=1
// -----------------------------------------------------------------------------
module cordic_ci_master #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int ERR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [ERR_W-1:0]  err_count,
  output logic              ci_clk_en,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  input  logic              ci_done,
  input  logic [DATA_W-1:0] ci_result
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] QNAN     = DATA_W'(32'h7FC0_0000);
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic                rdy_en_r;
  logic [DATA_W-1:0]   op_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   out_data_r;
  logic                out_err_r;
  logic [ERR_W-1:0]    err_count_r;

  logic                accept_s;
  logic                cap_done_s;
  logic                cap_timeout_s;
  logic                in_ready_s;
  logic                out_valid_s;
  logic                ci_start_s;
  logic                ci_clk_en_s;

  // Next-state decode plus the state-decoded handshake outputs.
  always_comb begin
    next_state_s  = state_r;
    accept_s      = 1'b0;
    cap_done_s    = 1'b0;
    cap_timeout_s = 1'b0;
    in_ready_s    = 1'b0;
    out_valid_s   = 1'b0;
    ci_start_s    = 1'b0;
    ci_clk_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // rdy_en_r keeps in_ready low while reset is held and for the
        // first cycle after release, so every output reads 0 in reset.
        in_ready_s = rdy_en_r;
        if (in_valid && rdy_en_r) begin
          accept_s     = 1'b1;
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        ci_start_s  = 1'b1;
        ci_clk_en_s = 1'b1;
        if (ci_done) begin
          cap_done_s   = 1'b1;
          next_state_s = ST_HOLD;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ci_clk_en_s = 1'b1;
        // done wins over a timeout landing in the same cycle
        if (ci_done) begin
          cap_done_s   = 1'b1;
          next_state_s = ST_HOLD;
        end else if (cnt_r == CNT_LAST) begin
          cap_timeout_s = 1'b1;
          next_state_s  = ST_HOLD;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        out_valid_s = 1'b1;
        in_ready_s  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            // back-to-back: skip IDLE entirely
            accept_s     = 1'b1;
            next_state_s = ST_ISSUE;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Ready enable: set once the block has seen one clock out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
    end
  end

  // Operand register; it is only loaded on acceptance, so ci_dataa stays
  // stable from ISSUE through the end of WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r <= '0;
    end else if (accept_s) begin
      op_r <= in_data;
    end
  end

  // WAIT cycle counter: cleared in ISSUE, counts every WAIT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (state_r == ST_ISSUE) begin
      cnt_r <= '0;
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Result register: loaded on done or timeout, otherwise held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_r <= '0;
      out_err_r  <= 1'b0;
    end else if (cap_done_s) begin
      out_data_r <= ci_result;
      out_err_r  <= 1'b0;
    end else if (cap_timeout_s) begin
      out_data_r <= QNAN;
      out_err_r  <= 1'b1;
    end
  end

  // Saturating timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_r <= '0;
    end else if (cap_timeout_s && (err_count_r != ERR_MAX)) begin
      err_count_r <= err_count_r + ERR_W'(1);
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = out_data_r;
  assign out_err   = out_err_r;
  assign err_count = err_count_r;
  assign ci_clk_en = ci_clk_en_s;
  assign ci_start  = ci_start_s;
  assign ci_dataa  = op_r;

endmodule

// File: tb/tb_cordic_ci_master.sv
// -----------------------------------------------------------------------------
// tb_cordic_ci_master
//   Self-checking bench for cordic_ci_master (TIMEOUT=16). A slave model
//   pulses done a programmable number of cycles after start. Expected results
//   come from a vector table and from a reference rule: done within TIMEOUT
//   cycles returns the slave value with latency L+1. Otherwise the result is a
//   qNaN with latency TIMEOUT+1 and the error count goes up.
// -----------------------------------------------------------------------------
module tb_cordic_ci_master;

  localparam int TO    = 16;
  localparam int NEVER = 1000;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [15:0] err_count;
  logic        ci_clk_en;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic        ci_done;
  logic [31:0] ci_result;

  cordic_ci_master #(.DATA_W(32), .TIMEOUT(TO), .ERR_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .err_count(err_count),
    .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_dataa(ci_dataa),
    .ci_done(ci_done), .ci_result(ci_result)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int model_errs = 0;

  // slave model controls
  int          lat_s     = NEVER;
  logic [31:0] ret_s     = 32'h0;
  logic        echo_s    = 1'b0;
  logic        stray_req = 1'b0;
  int          age;
  logic        pend;

  typedef struct {
    logic [31:0] operand;
    int          lat;
    logic [31:0] ret;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          hold_n;
  } vec_t;

  vec_t vecs[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: done pulse lat_s cycles after the start cycle, or a stray pulse on request.
  initial begin
    ci_done = 1'b0; ci_result = 32'h0; pend = 1'b0; age = 0;
    forever begin
      @(negedge clk); #1;
      ci_done = 1'b0; ci_result = 32'h0;
      if (!reset) pend = 1'b0;
      else if (ci_start) begin pend = 1'b1; age = 0; end
      else if (pend) age++;
      if (pend && age == lat_s) begin
        ci_done = 1'b1;
        ci_result = echo_s ? ~ci_dataa : ret_s;
        pend = 1'b0;
      end else if (stray_req) begin
        ci_done = 1'b1;
        ci_result = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One complete operation from an idle block; optional stalled HOLD phase.
  task automatic run_op(input logic [31:0] operand, input int lat, input logic [31:0] ret,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                        input int hold_n, input string nm);
    int t0;
    int n;
    logic ok;
    lat_s = lat; ret_s = ret; echo_s = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = operand; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_data = $urandom;
    chk({nm, "_start"}, {31'b0, ci_start}, 32'd1);
    chk({nm, "_dataa"}, ci_dataa, operand);
    t0 = cyc; n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    chk({nm, "_lat"}, 32'(cyc - t0), 32'(exp_lat));
    chk({nm, "_data"}, out_data, exp_data);
    chk({nm, "_err"}, {31'b0, out_err}, {31'b0, exp_err});
    chk({nm, "_errcnt"}, {16'b0, err_count}, 32'(model_errs));
    if (hold_n > 0) begin
      ok = 1'b1;
      in_valid = 1'b1; in_data = 32'hAAAA_5555; stray_req = 1'b1;
      for (int i = 0; i < hold_n; i++) begin
        @(negedge clk);
        stray_req = 1'b0;
        if (!(out_valid && !in_ready && !ci_clk_en && !ci_start &&
              out_data == exp_data && out_err == exp_err)) ok = 1'b0;
      end
      in_valid = 1'b0;
      chk({nm, "_hold_stable"}, {31'b0, ok}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_idle"}, {30'b0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    int t0;
    int n;
    int l;
    logic ok;
    logic [31:0] op;
    logic [31:0] rv;

    vecs[0] = '{32'hBF80_0000, 5,     32'h3F0A_5140, 32'h3F0A_5140, 1'b0, 6,  0};
    vecs[1] = '{32'h3F80_0000, 0,     32'h3F5A_8279, 32'h3F5A_8279, 1'b0, 1,  0};
    vecs[2] = '{32'h4049_0FDB, NEVER, 32'h1234_5678, QNAN,          1'b1, 17, 0};
    vecs[3] = '{32'h3E80_0000, 3,     32'h3F77_F7A6, 32'h3F77_F7A6, 1'b0, 4,  10};
    vecs[4] = '{32'hC000_0000, 16,    32'h3ED5_1A4F, 32'h3ED5_1A4F, 1'b0, 17, 0};
    vecs[5] = '{32'h0000_0000, 15,    32'h3F80_0000, 32'h3F80_0000, 1'b0, 16, 0};

    reset = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {27'b0, in_ready, out_valid, ci_clk_en, ci_start, out_err}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_dataa", ci_dataa, 32'h0);
    chk("rst_errcnt", {16'b0, err_count}, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", {31'b0, in_ready}, 32'd1);

    // table vectors: basic, zero latency, timeout, stalled hold, coincident, TO-1
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].exp_err) model_errs++;
      run_op(vecs[i].operand, vecs[i].lat, vecs[i].ret, vecs[i].exp_data,
             vecs[i].exp_err, vecs[i].exp_lat, vecs[i].hold_n, $sformatf("vec%0d", i));
    end

    // back-to-back with out_ready tied high
    lat_s = 5; echo_s = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hBF80_0000;
    @(negedge clk);
    t0 = cyc; in_data = 32'h3F80_0000;
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    chk("b2b_lat1", 32'(cyc - t0), 32'd6);
    chk("b2b_data1", out_data, 32'h407F_FFFF);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_start2", {31'b0, ci_start}, 32'd1);
    chk("b2b_gap", 32'(cyc - t0), 32'd7);
    chk("b2b_dataa2", ci_dataa, 32'h3F80_0000);
    t0 = cyc; n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    chk("b2b_lat2", 32'(cyc - t0), 32'd6);
    chk("b2b_data2", out_data, 32'hC07F_FFFF);
    @(negedge clk);
    out_ready = 1'b0; echo_s = 1'b0;
    chk("b2b_idle", {30'b0, out_valid, in_ready}, 32'b01);

    // stray done while idle
    stray_req = 1'b1;
    @(negedge clk);
    stray_req = 1'b0;
    @(negedge clk);
    chk("stray_idle_ctrl", {29'b0, out_valid, ci_clk_en, in_ready}, 32'b001);
    chk("stray_idle_data", out_data, 32'hC07F_FFFF);

    // reset in the middle of WAIT
    lat_s = NEVER;
    in_valid = 1'b1; in_data = 32'h3F00_0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst_ctrl", {29'b0, ci_clk_en, ci_start, out_valid}, 32'h0);
    chk("midrst_errcnt", {16'b0, err_count}, 32'h0);
    model_errs = 0;
    @(negedge clk);
    reset = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid || ci_start) ok = 1'b0;
    end
    chk("midrst_quiet", {31'b0, ok}, 32'd1);
    chk("midrst_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_errcnt2", {16'b0, err_count}, 32'h0);

    // randomized operations against the reference rule
    for (int i = 0; i < 20; i++) begin
      op = $urandom; rv = $urandom; l = $urandom_range(0, TO + 3);
      if (l > TO) begin
        model_errs++;
        run_op(op, NEVER, rv, QNAN, 1'b1, TO + 1, 0, $sformatf("rnd%0d", i));
      end else begin
        run_op(op, l, rv, rv, 1'b0, l + 1, 0, $sformatf("rnd%0d", i));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
